// File: rtl/instr_fetch_unit_if.sv
// Bus between the host/testbench and instr_fetch_unit: program-load port,
// run control inputs and the registered instruction stream to the core.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic              start;
  logic              hold;
  logic [15:0]       instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        state;

  // Host side: loads program memory and controls execution.
  modport master (
    output prog_we, prog_addr, prog_data, start, hold,
    input  instruction, instr_valid, pc, state
  );

  // Fetch unit side.
  modport slave (
    input  prog_we, prog_addr, prog_data, start, hold,
    output instruction, instr_valid, pc, state
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: small program memory plus IDLE/RUN/HOLD/HALTED
// sequencer issuing one 16-bit word per clock to the core.
// Optional macro FETCH_WRAP_EN: when defined, a fetch from the last address
// wraps pc to 0 and keeps running; otherwise it halts after that fetch.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned PMEM_DEPTH = 2**ADDR_W,
  parameter logic [15:0] NOP_WORD   = 16'hF000,
  parameter logic [15:0] HALT_WORD  = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_unit_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HOLD   = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [15:0]       pmem_q [PMEM_DEPTH];
  logic [15:0]       pmem_d [PMEM_DEPTH];

  logic [15:0]       fetch_word;
  logic              last_addr;
  logic              prog_open;

  assign fetch_word = pmem_q[pc_q];
  assign last_addr  = (pc_q == ADDR_W'(PMEM_DEPTH - 1));
  assign prog_open  = (state_q == ST_IDLE) || (state_q == ST_HALTED);

  // Program-memory write port, open only while not executing.
  always_comb begin
    pmem_d = pmem_q;
    if (prog_open && bus.prog_we) begin
      pmem_d[bus.prog_addr] = bus.prog_data;
    end
  end

  // Sequencer next-state: outputs default to NOP/invalid unless a word issues.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = NOP_WORD;
    valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN, ST_HOLD: begin
        if (bus.hold) begin
          state_d = ST_HOLD;
        end else if (fetch_word == HALT_WORD) begin
          state_d = ST_HALTED;
        end else begin
          instr_d = fetch_word;
          valid_d = 1'b1;
          if (last_addr) begin
`ifdef FETCH_WRAP_EN
            pc_d    = '0;
            state_d = ST_RUN;
`else
            state_d = ST_HALTED;
`endif
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  // Program memory; reset clears every word to NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < PMEM_DEPTH; i++) begin
        pmem_q[i] <= NOP_WORD;
      end
    end else begin
      pmem_q <= pmem_d;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.state       = state_q;

endmodule
